// File: rtl/tone_synth.sv
// Beat-sequenced square-wave tone player: requests a note code, latches it, plays it for one beat.
// Optional macro TONE_SYNTH_ARTIC_EN silences the last GAP_CYCLES cycles of each PLAY phase.
module tone_synth #(
  parameter int unsigned BEAT_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 625000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] tune_code,
  output logic       trigger,
  output logic       audio_out,
  output logic [3:0] cur_code,
  output logic       note_valid
);

  localparam int unsigned CNT_W  = $clog2(BEAT_CYCLES);
  localparam int unsigned DIV_W  = 17;
  localparam int unsigned CODE_W = 4;
  localparam logic [CNT_W-1:0]  LAST_PLAY = CNT_W'(BEAT_CYCLES - 3);
  localparam logic [CODE_W-1:0] MAX_NOTE  = CODE_W'(8);
`ifdef TONE_SYNTH_ARTIC_EN
  localparam logic [CNT_W-1:0]  GAP_START = CNT_W'(BEAT_CYCLES - 2 - GAP_CYCLES);
`endif

  // Reject parameter sets that leave no room for FETCH/LATCH or a non-empty tone phase.
  if (BEAT_CYCLES < 8 || GAP_CYCLES >= BEAT_CYCLES - 2) begin : g_bad_params
    $error("tone_synth: BEAT_CYCLES must be >= 8 and GAP_CYCLES < BEAT_CYCLES-2");
  end

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, PLAY} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   beat_cnt, cnt_nxt;
  logic [DIV_W-1:0]   divider, div_nxt;
  logic               tone, tone_nxt;
  logic [CODE_W-1:0]  code_nxt;
  logic               play_nxt, gap_nxt, note_nxt;

  // Half-period minus one, in 50 MHz clock cycles; rests return 0 and never use it.
  function automatic logic [DIV_W-1:0] half_period_m1(input logic [CODE_W-1:0] code);
    case (code)
      4'd0:    half_period_m1 = 17'd127550;
      4'd1:    half_period_m1 = 17'd113635;
      4'd2:    half_period_m1 = 17'd101238;
      4'd3:    half_period_m1 = 17'd95555;
      4'd4:    half_period_m1 = 17'd85131;
      4'd5:    half_period_m1 = 17'd75842;
      4'd6:    half_period_m1 = 17'd63775;
      4'd7:    half_period_m1 = 17'd56817;
      4'd8:    half_period_m1 = 17'd47777;
      default: half_period_m1 = '0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    div_nxt   = divider;
    tone_nxt  = tone;
    code_nxt  = cur_code;
    case (state)
      IDLE: begin
        tone_nxt = 1'b0;
        if (enable) state_nxt = FETCH;
      end
      FETCH: state_nxt = LATCH;
      LATCH: begin
        code_nxt  = tune_code;
        div_nxt   = half_period_m1(tune_code);
        cnt_nxt   = '0;
        tone_nxt  = 1'b0;
        state_nxt = PLAY;
      end
      PLAY: begin
        if (cur_code <= MAX_NOTE) begin
          if (divider == '0) begin
            div_nxt  = half_period_m1(cur_code);
            tone_nxt = ~tone;
          end else begin
            div_nxt = divider - DIV_W'(1);
          end
        end
        // Enable is only consulted on the final PLAY cycle so a beat is never cut short.
        if (beat_cnt == LAST_PLAY) begin
          state_nxt = enable ? FETCH : IDLE;
          tone_nxt  = 1'b0;
        end else begin
          cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    play_nxt = (state_nxt == PLAY);
`ifdef TONE_SYNTH_ARTIC_EN
    gap_nxt  = play_nxt && (cnt_nxt >= GAP_START);
`else
    gap_nxt  = 1'b0;
`endif
    note_nxt = play_nxt && (code_nxt <= MAX_NOTE) && !gap_nxt;
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt   <= '0;
      divider    <= '0;
      tone       <= 1'b0;
      trigger    <= 1'b1;
      audio_out  <= 1'b0;
      cur_code   <= '0;
      note_valid <= 1'b0;
    end else begin
      beat_cnt   <= cnt_nxt;
      divider    <= div_nxt;
      tone       <= tone_nxt;
      trigger    <= (state_nxt != FETCH);
      audio_out  <= tone_nxt && note_nxt;
      cur_code   <= code_nxt;
      note_valid <= note_nxt;
    end
  end

endmodule
